// File: rtl/counter_pkg.sv
// Shared definitions for the up/down counter family: direction encodings
// and the load-value clamp used when a parallel load exceeds the modulus.
package counter_pkg;

  localparam logic CNT_UP   = 1'b1;
  localparam logic CNT_DOWN = 1'b0;

  // Values at or above the modulus are pinned to the largest legal count,
  // so a bad load can never put the counter outside 0..modulus-1.
  function automatic logic [31:0] clamp_load(input logic [31:0] value,
                                             input logic [32:0] modulus);
    logic [32:0] top_value;
    top_value = modulus - 33'd1;
    if ({1'b0, value} < modulus) begin
      return value;
    end
    return top_value[31:0];
  endfunction

endpackage

// File: rtl/counter_step.sv
// Combinational next-count calculation for updown_counter.
// Optional feature macro: UPDOWN_COUNTER_SATURATE_EN -- when defined the
// counter holds at its limits; otherwise it wraps modulo MODULUS.
module counter_step
  import counter_pkg::*;
#(
  parameter int              WIDTH   = 4,
  parameter longint unsigned MODULUS = 64'd1 << WIDTH
) (
  input  logic [WIDTH-1:0] count,
  input  logic             up,
  output logic [WIDTH-1:0] next_count,
  output logic             at_limit
);

  // One extra bit of headroom so MODULUS = 2**WIDTH compares exactly.
  localparam logic [WIDTH:0]   MOD_EXT = MODULUS[WIDTH:0];
  localparam logic [WIDTH:0]   ONE_EXT = {{WIDTH{1'b0}}, 1'b1};
  localparam logic [WIDTH:0]   MAX_EXT = MOD_EXT - ONE_EXT;
  localparam logic [WIDTH-1:0] MAX     = MAX_EXT[WIDTH-1:0];

`ifdef UPDOWN_COUNTER_SATURATE_EN
  localparam logic [WIDTH-1:0] UP_LIMIT_NEXT   = MAX;
  localparam logic [WIDTH-1:0] DOWN_LIMIT_NEXT = '0;
`else
  localparam logic [WIDTH-1:0] UP_LIMIT_NEXT   = '0;
  localparam logic [WIDTH-1:0] DOWN_LIMIT_NEXT = MAX;
`endif

  logic [WIDTH:0] count_ext;
  logic [WIDTH:0] sum_ext;
  logic [WIDTH:0] diff_ext;
  logic           top_reached;
  logic           bottom_reached;

  assign count_ext      = {1'b0, count};
  assign sum_ext        = count_ext + ONE_EXT;
  assign diff_ext       = count_ext - ONE_EXT;
  assign top_reached    = (sum_ext == MOD_EXT);
  assign bottom_reached = diff_ext[WIDTH];

  // Pick the stepped value, substituting the limit behaviour at either end.
  always_comb begin
    next_count = count;
    at_limit   = 1'b0;
    if (up == CNT_UP) begin
      at_limit   = top_reached;
      next_count = top_reached ? UP_LIMIT_NEXT : sum_ext[WIDTH-1:0];
    end else begin
      at_limit   = bottom_reached;
      next_count = bottom_reached ? DOWN_LIMIT_NEXT : diff_ext[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/updown_counter.sv
// Synchronous parametrised up/down counter with load, terminal count and
// a registered wrap pulse. Priority per edge: reset > load > enable > hold.
// Optional feature macro: UPDOWN_COUNTER_SATURATE_EN -- saturate at the
// limits instead of wrapping; wrap then never asserts.
module updown_counter
  import counter_pkg::*;
#(
  parameter int              WIDTH   = 4,
  parameter longint unsigned MODULUS = 64'd1 << WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap
);

`ifdef UPDOWN_COUNTER_SATURATE_EN
  localparam logic WRAP_ALLOWED = 1'b0;
`else
  localparam logic WRAP_ALLOWED = 1'b1;
`endif

  logic [WIDTH-1:0] next_count;
  logic             at_limit;
  logic [WIDTH-1:0] load_count;

  counter_step #(
    .WIDTH   (WIDTH),
    .MODULUS (MODULUS)
  ) u_step (
    .count      (count),
    .up         (up),
    .next_count (next_count),
    .at_limit   (at_limit)
  );

  assign load_count = WIDTH'(clamp_load(32'(load_value), 33'(MODULUS)));

  // Terminal count is a pure function of the current count and direction,
  // so a following stage can be enabled with enable & tc in the same cycle.
  assign tc = at_limit;

  // Count register and wrap pulse, applying the reset/load/enable priority.
  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
      wrap  <= 1'b0;
    end else if (load) begin
      count <= load_count;
      wrap  <= 1'b0;
    end else if (enable) begin
      count <= next_count;
      wrap  <= WRAP_ALLOWED & at_limit;
    end else begin
      wrap  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_updown_counter.sv
// Directed self-checking bench for updown_counter: a WIDTH=4/MODULUS=10
// counter plus a chained pair of WIDTH=2/MODULUS=4 counters.
// Saturating expectations are selected with UPDOWN_COUNTER_SATURATE_EN.
module tb_updown_counter;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic       up = 1'b1;
  logic       load = 1'b0;
  logic [3:0] load_value = '0;
  logic [3:0] count;
  logic       tc;
  logic       wrap;

  logic       chain_en = 1'b0;
  logic [1:0] lo_count;
  logic [1:0] hi_count;
  logic       lo_tc;
  logic       hi_tc;
  logic       lo_wrap;
  logic       hi_wrap;

  int compared   = 0;
  int mismatched = 0;

  always #5 clock = ~clock;

  updown_counter #(.WIDTH(4), .MODULUS(10)) dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .up         (up),
    .load       (load),
    .load_value (load_value),
    .count      (count),
    .tc         (tc),
    .wrap       (wrap)
  );

  updown_counter #(.WIDTH(2), .MODULUS(4)) chain_lo (
    .clock      (clock),
    .reset      (reset),
    .enable     (chain_en),
    .up         (1'b1),
    .load       (1'b0),
    .load_value (2'd0),
    .count      (lo_count),
    .tc         (lo_tc),
    .wrap       (lo_wrap)
  );

  updown_counter #(.WIDTH(2), .MODULUS(4)) chain_hi (
    .clock      (clock),
    .reset      (reset),
    .enable     (chain_en & lo_tc),
    .up         (1'b1),
    .load       (1'b0),
    .load_value (2'd0),
    .count      (hi_count),
    .tc         (hi_tc),
    .wrap       (hi_wrap)
  );

  // Drive the main counter's inputs, then let one rising edge pass and
  // settle 1 time unit past it before anything is sampled.
  task automatic apply_stimulus(input logic rst, input logic ld, input logic en,
                                input logic dir, input logic [3:0] value);
    reset      = rst;
    load       = ld;
    enable     = en;
    up         = dir;
    load_value = value;
    @(posedge clock);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Expected counts after each of 12 enabled up-steps starting from 0.
  int up_counts[12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};

  initial begin
    // Reset dominates load and enable.
    @(negedge clock);
    apply_stimulus(1'b1, 1'b1, 1'b1, 1'b1, 4'd5);
    check_output("reset_count", 32'(count), 32'd0);
    check_output("reset_wrap", 32'(wrap), 32'd0);
    check_output("reset_tc_up", 32'(tc), 32'd0);
    up = 1'b0;
    #1;
    check_output("reset_tc_down", 32'(tc), 32'd1);
    check_output("reset_chain", 32'({hi_count, lo_count}), 32'd0);

    // Up count through the modulus: wrap only on the return to 0.
    for (int i = 0; i < 12; i++) begin
      apply_stimulus(1'b0, 1'b0, 1'b1, 1'b1, 4'd0);
      check_output($sformatf("up_count_%0d", i), 32'(count), 32'(up_counts[i]));
      check_output($sformatf("up_wrap_%0d", i), 32'(wrap), (i == 9) ? 32'd1 : 32'd0);
      check_output($sformatf("up_tc_%0d", i), 32'(tc), (i == 8) ? 32'd1 : 32'd0);
    end

    // Load 1 with enable low, then count down 0, 9, 8.
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 4'd1);
    check_output("down_load", 32'(count), 32'd1);
    check_output("down_load_tc", 32'(tc), 32'd0);
    apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
    check_output("down_0", 32'(count), 32'd0);
    check_output("down_0_wrap", 32'(wrap), 32'd0);
    check_output("down_0_tc", 32'(tc), 32'd1);
    apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
    check_output("down_9", 32'(count), 32'd9);
    check_output("down_9_wrap", 32'(wrap), 32'd1);
    check_output("down_9_tc", 32'(tc), 32'd0);
    apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
    check_output("down_8", 32'(count), 32'd8);
    check_output("down_8_wrap", 32'(wrap), 32'd0);

    // Hold keeps the count and clears wrap.
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    check_output("hold_count", 32'(count), 32'd8);
    check_output("hold_wrap", 32'(wrap), 32'd0);

    // Over-range load clamps to 9 and suppresses the step.
    apply_stimulus(1'b0, 1'b1, 1'b1, 1'b1, 4'd13);
    check_output("clamp_count", 32'(count), 32'd9);
    check_output("clamp_wrap", 32'(wrap), 32'd0);
    check_output("clamp_tc", 32'(tc), 32'd1);

    // Reset beats a simultaneous load.
    apply_stimulus(1'b1, 1'b1, 1'b0, 1'b1, 4'd4);
    check_output("reset_over_load", 32'(count), 32'd0);

    // Direction change applies on the very next step.
    apply_stimulus(1'b0, 1'b0, 1'b1, 1'b1, 4'd0);
    check_output("dir_up", 32'(count), 32'd1);
    apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
    check_output("dir_down", 32'(count), 32'd0);

    // Limit behaviour from 8 upward and from 1 downward.
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b1, 4'd8);
    check_output("limit_load8", 32'(count), 32'd8);
`ifdef UPDOWN_COUNTER_SATURATE_EN
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(1'b0, 1'b0, 1'b1, 1'b1, 4'd0);
      check_output($sformatf("sat_up_%0d", i), 32'(count), 32'd9);
      check_output($sformatf("sat_up_wrap_%0d", i), 32'(wrap), 32'd0);
      check_output($sformatf("sat_up_tc_%0d", i), 32'(tc), 32'd1);
    end
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 4'd1);
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
      check_output($sformatf("sat_down_%0d", i), 32'(count), 32'd0);
      check_output($sformatf("sat_down_wrap_%0d", i), 32'(wrap), 32'd0);
    end
`else
    apply_stimulus(1'b0, 1'b0, 1'b1, 1'b1, 4'd0);
    check_output("mod_up_9", 32'(count), 32'd9);
    apply_stimulus(1'b0, 1'b0, 1'b1, 1'b1, 4'd0);
    check_output("mod_up_0", 32'(count), 32'd0);
    check_output("mod_up_0_wrap", 32'(wrap), 32'd1);
    apply_stimulus(1'b0, 1'b0, 1'b1, 1'b1, 4'd0);
    check_output("mod_up_1", 32'(count), 32'd1);
    check_output("mod_up_1_wrap", 32'(wrap), 32'd0);
`endif

    // Chained pair: 16 enabled cycles walk the combined value 1..15, 0.
    enable = 1'b0;
    chain_en = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      @(posedge clock);
      #1;
      check_output($sformatf("chain_%0d", i), 32'({hi_count, lo_count}),
                   32'(i % 16));
    end
    chain_en = 1'b0;
    check_output("chain_hi_wrap", 32'(hi_wrap), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
